// File: rtl/risc_pkg.sv
// risc_pkg: shared definitions for the 16-bit RISC_PROC pipeline.
//   DEF_DATA_W / DEF_ADDR_W : default instruction and word-address widths
//   OPCODE_MSB / OPCODE_LSB : position of the opcode field in an instruction
//   NOP_INSTR               : bubble instruction (opcode 0000 decodes to no control)
//   if_state_e              : fetch-stage state encoding
//   opcode_of()             : extract the opcode field from an instruction
package risc_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 16;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 12;

  localparam logic [15:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    SQUASH = 2'd1,
    HELD   = 2'd2
  } if_state_e;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/pc_next_mux.sv
// pc_next_mux: priority select of the next program counter.
//   pcsrc2 / jump_target   : EX-resolved redirect (highest priority, oldest)
//   pcsrc1 / branch_target : ID-resolved redirect
//   hold                   : keep the current pc
//   pc                     : current pc
//   pc_next                : selected next pc (pc+1 wraps modulo 2^ADDR_W)
module pc_next_mux
  import risc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              pcsrc2,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              pcsrc1,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              hold,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next
);

  always_comb begin
    if (pcsrc2) begin
      pc_next = jump_target;
    end else if (pcsrc1) begin
      pc_next = branch_target;
    end else if (hold) begin
      pc_next = pc;
    end else begin
      pc_next = pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/if_stage.sv
// if_stage: instruction fetch and IF/ID pipeline register.
//   clk, rst_n                 : clock (rising edge), async active-low reset
//   imem_req/addr/ack/rdata    : request/acknowledge instruction-memory port
//   stall                      : hold IF/ID and pc
//   pcsrc1/branch_target       : ID-resolved redirect
//   pcsrc2/jump_target         : EX-resolved redirect (wins over pcsrc1)
//   if_id_flush                : bubble the IF/ID register
//   if_id_instr/pc1/valid      : registered instruction, its pc+1, valid flag
module if_stage
  import risc_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              pcsrc1,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              pcsrc2,
  input  logic [ADDR_W-1:0] jump_target,
  input  logic              if_id_flush,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc1,
  output logic              if_id_valid
);

  if_state_e         state_q, state_d;
  logic              req_en_q, req_en_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pc_plus1;
  logic [ADDR_W-1:0] squash_addr_q, squash_addr_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_instr_q, skid_instr_d;
  logic [ADDR_W-1:0] skid_pc1_q, skid_pc1_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] pc1_q, pc1_d;
  logic              valid_q, valid_d;
  logic              redirect, ack, pc_hold, fetch_load, skid_load, skid_write;

  // An ack only counts when we are actually requesting; anything else is void.
  assign redirect = pcsrc1 | pcsrc2;
  assign ack      = imem_ack & imem_req;
  assign pc_plus1 = pc_q + ADDR_W'(1);

  // The pc only moves sequentially when a fetch completes; a stall that
  // coincides with the ack still advances it because the data goes to the skid.
  assign pc_hold    = !((state_q == FETCH) && ack);
  assign fetch_load = (state_q == FETCH) && ack && !redirect && !stall;
  assign skid_write = (state_q == FETCH) && ack && !redirect && stall;
  assign skid_load  = (state_q == HELD) && !redirect && !stall && skid_valid_q;

  pc_next_mux #(.ADDR_W(ADDR_W)) u_pc_next_mux (
    .pcsrc2        (pcsrc2),
    .jump_target   (jump_target),
    .pcsrc1        (pcsrc1),
    .branch_target (branch_target),
    .hold          (pc_hold),
    .pc            (pc_q),
    .pc_next       (pc_d)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. A redirect without an ack must wait out the
  // outstanding request in SQUASH so its data can be thrown away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (redirect) begin
          state_d = ack ? FETCH : SQUASH;
        end else if (ack && stall) begin
          state_d = HELD;
        end
      end
      SQUASH: begin
        if (ack) begin
          state_d = FETCH;
        end
      end
      HELD: begin
        if (redirect || !stall) begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // Memory port outputs. SQUASH keeps presenting the old address until the
  // pending request is acknowledged.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q;
    case (state_q)
      FETCH: imem_req = req_en_q;
      SQUASH: begin
        imem_req  = 1'b1;
        imem_addr = squash_addr_q;
      end
      default: imem_req = 1'b0;
    endcase
  end

  // Datapath: request enable, squash address, skid buffer and IF/ID.
  // The request enable holds imem_req low until the first edge out of reset.
  always_comb begin
    req_en_d      = 1'b1;
    squash_addr_d = (state_q == FETCH) ? pc_q : squash_addr_q;

    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_pc1_d   = skid_pc1_q;
    if (skid_write) begin
      skid_valid_d = 1'b1;
      skid_instr_d = imem_rdata;
      skid_pc1_d   = pc_plus1;
    end else if ((state_q == HELD) && (redirect || !stall)) begin
      skid_valid_d = 1'b0;
      skid_instr_d = DATA_W'(NOP_INSTR);
      skid_pc1_d   = '0;
    end

    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    if (if_id_flush) begin
      instr_d = DATA_W'(NOP_INSTR);
      pc1_d   = '0;
      valid_d = 1'b0;
    end else if (stall) begin
      valid_d = valid_q;
    end else if (fetch_load) begin
      instr_d = imem_rdata;
      pc1_d   = pc_plus1;
      valid_d = 1'b1;
    end else if (skid_load) begin
      instr_d = skid_instr_q;
      pc1_d   = skid_pc1_q;
      valid_d = 1'b1;
    end else begin
      instr_d = DATA_W'(NOP_INSTR);
      pc1_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_en_q      <= 1'b0;
      pc_q          <= RESET_PC;
      squash_addr_q <= RESET_PC;
      skid_valid_q  <= 1'b0;
      skid_instr_q  <= DATA_W'(NOP_INSTR);
      skid_pc1_q    <= '0;
      instr_q       <= DATA_W'(NOP_INSTR);
      pc1_q         <= '0;
      valid_q       <= 1'b0;
    end else begin
      req_en_q      <= req_en_d;
      pc_q          <= pc_d;
      squash_addr_q <= squash_addr_d;
      skid_valid_q  <= skid_valid_d;
      skid_instr_q  <= skid_instr_d;
      skid_pc1_q    <= skid_pc1_d;
      instr_q       <= instr_d;
      pc1_q         <= pc1_d;
      valid_q       <= valid_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_pc1   = pc1_q;
  assign if_id_valid = valid_q;

endmodule
